// File: rtl/btn_pkg.sv
// Shared definitions for the push-button reader.
//   btn_state_t : per-button debounce FSM state
//   NUM_BTN_DEF : default number of buttons
//   KEY_W       : width of the key event code
//   CNT_W       : width of the per-button debounce counter
package btn_pkg;

    localparam int NUM_BTN_DEF = 5;
    localparam int KEY_W       = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } btn_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchronizer + debounce FSM.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   readTick   : sample enable, FSM advances only when high
//   btnRaw     : raw asynchronous button level (1 = pressed)
//   btnLevel   : debounced level, 1 in HELD and REL_WAIT
//   pressPulse : one-cycle strobe when a press is accepted
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic readTick,
    input  logic btnRaw,
    output logic btnLevel,
    output logic pressPulse
);

    localparam logic [CNT_W-1:0] LP_N = CNT_W'(DEBOUNCE_N);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] w_cnt_inc;

    // Counter never passes DEBOUNCE_N, so it can never wrap.
    assign w_cnt_inc = (r_cnt >= LP_N) ? LP_N : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= btnRaw;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (readTick) begin
                case (r_state)
                    IDLE: begin
                        if (r_sync2) begin
                            r_state <= PRESS_WAIT;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (r_sync2) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LP_N) begin
                                r_state <= HELD;
                                r_level <= 1'b1;
                                r_pulse <= 1'b1;
                            end
                        end else begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    HELD: begin
                        if (!r_sync2) begin
                            r_state <= REL_WAIT;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    REL_WAIT: begin
                        if (!r_sync2) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == LP_N) begin
                                r_state <= IDLE;
                                r_level <= 1'b0;
                                r_cnt   <= '0;
                            end
                        end else begin
                            // Release glitch: back to HELD with no new pulse.
                            r_state <= HELD;
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign btnLevel   = r_level;
    assign pressPulse = r_pulse;

endmodule

// File: rtl/btn_reader.sv
// Push-button reader: NUM_BTN debouncers feeding a one-entry key event register.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   readTick   : debounce sample enable
//   btnRaw     : raw button levels
//   btnLevel   : debounced levels
//   pressPulse : per-button accepted-press strobes
//   keyValid   : event register holds an event
//   keyCode    : button index of the held event
//   keyReady   : consumer accepts the held event
//   overflow   : sticky, an event was dropped
//   clrOvf     : clears overflow (a same-cycle drop wins)
module btn_reader
    import btn_pkg::*;
#(
    parameter int NUM_BTN    = NUM_BTN_DEF,
    parameter int DEBOUNCE_N = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               readTick,
    input  logic [NUM_BTN-1:0] btnRaw,
    output logic [NUM_BTN-1:0] btnLevel,
    output logic [NUM_BTN-1:0] pressPulse,
    output logic               keyValid,
    output logic [KEY_W-1:0]   keyCode,
    input  logic               keyReady,
    output logic               overflow,
    input  logic               clrOvf
);

    logic [NUM_BTN-1:0] w_pulse;
    logic [KEY_W-1:0]   w_code;
    logic               w_any;
    logic               w_multi;
    logic               w_drain;
    logic               w_load;
    logic               w_drop;
    logic               r_valid;
    logic [KEY_W-1:0]   r_code;
    logic               r_ovf;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_N (DEBOUNCE_N)
        ) u_db (
            .clk        (clk),
            .rst        (rst),
            .readTick   (readTick),
            .btnRaw     (btnRaw[g]),
            .btnLevel   (btnLevel[g]),
            .pressPulse (w_pulse[g])
        );
    end

    // Lowest set index wins.
    always_comb begin
        w_code = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_pulse[i]) w_code = KEY_W'(i);
        end
    end

    assign w_any   = |w_pulse;
    assign w_multi = |(w_pulse & (w_pulse - NUM_BTN'(1)));
    assign w_drain = r_valid & keyReady;
    assign w_load  = w_any & (~r_valid | keyReady);
    // Extra pulses in one cycle, or a pulse into a full, non-draining register.
    assign w_drop  = w_multi | (w_any & r_valid & ~keyReady);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_code  <= w_code;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end
            if (w_drop)      r_ovf <= 1'b1;
            else if (clrOvf) r_ovf <= 1'b0;
        end
    end

    assign pressPulse = w_pulse;
    assign keyValid   = r_valid;
    assign keyCode    = r_code;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_btn_reader.sv
module tb_btn_reader;

    localparam int NB = 5;

    logic          clk;
    logic          rst;
    logic          readTick;
    logic [NB-1:0] btnRaw;
    logic [NB-1:0] btnLevel;
    logic [NB-1:0] pressPulse;
    logic          keyValid;
    logic [2:0]    keyCode;
    logic          keyReady;
    logic          overflow;
    logic          clrOvf;

    int total = 0;
    int bad   = 0;

    logic [2:0] sb[$];

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] pls;
    } vec_t;

    vec_t tbl[$];

    btn_reader #(.NUM_BTN(NB), .DEBOUNCE_N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .readTick   (readTick),
        .btnRaw     (btnRaw),
        .btnLevel   (btnLevel),
        .pressPulse (pressPulse),
        .keyValid   (keyValid),
        .keyCode    (keyCode),
        .keyReady   (keyReady),
        .overflow   (overflow),
        .clrOvf     (clrOvf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sync settles, then one readTick cycle; returns on the negedge after the tick.
    task automatic tick();
        repeat (5) @(negedge clk);
        readTick = 1'b1;
        @(negedge clk);
        readTick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_ovf();
        clrOvf = 1'b1;
        @(negedge clk);
        clrOvf = 1'b0;
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
    endtask

    task automatic add(input logic [NB-1:0] r, input logic [NB-1:0] l, input logic [NB-1:0] p);
        vec_t v;
        v.raw = r; v.lvl = l; v.pls = p;
        tbl.push_back(v);
    endtask

    // Scoreboard consumer: handshake as the next posedge will see it.
    always begin
        @(negedge clk);
        #1;
        if (rst && keyValid && keyReady) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got code %0d want no event", keyCode);
            end else begin
                chk("sb_code", {29'd0, keyCode}, {29'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; readTick = 1'b0; btnRaw = '0; keyReady = 1'b1; clrOvf = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", {27'd0, btnLevel}, 32'd0);
        chk("rst_pulse", {27'd0, pressPulse}, 32'd0);
        chk("rst_valid", {31'd0, keyValid}, 32'd0);
        chk("rst_code",  {29'd0, keyCode}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        rst = 1'b1;

        // bounce on btn0: 1,1,0,1,1,1,1 then release
        add(5'b00001, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00001, 5'b00001);
        for (int k = 0; k < 3; k++) add(5'b00000, 5'b00001, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000);
        // btn1 press, 2-tick release glitch, then real release
        for (int k = 0; k < 3; k++) add(5'b00010, 5'b00000, 5'b00000);
        add(5'b00010, 5'b00010, 5'b00010);
        add(5'b00000, 5'b00010, 5'b00000);
        add(5'b00000, 5'b00010, 5'b00000);
        add(5'b00010, 5'b00010, 5'b00000);
        add(5'b00010, 5'b00010, 5'b00000);
        for (int k = 0; k < 3; k++) add(5'b00000, 5'b00010, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000);
        // clean press on btn2
        for (int k = 0; k < 3; k++) add(5'b00100, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00100, 5'b00100);
        add(5'b00100, 5'b00100, 5'b00000);
        for (int k = 0; k < 3; k++) add(5'b00000, 5'b00100, 5'b00000);
        add(5'b00000, 5'b00000, 5'b00000);

        foreach (tbl[i]) begin
            btnRaw = tbl[i].raw;
            for (int b = NB - 1; b >= 0; b--) begin
                if (tbl[i].pls == (NB'(1) << b)) sb.push_back(3'(b));
            end
            tick();
            chk($sformatf("lvl[%0d]", i), {27'd0, btnLevel}, {27'd0, tbl[i].lvl});
            chk($sformatf("pls[%0d]", i), {27'd0, pressPulse}, {27'd0, tbl[i].pls});
            @(negedge clk);
            chk($sformatf("pls_w[%0d]", i), {27'd0, pressPulse}, 32'd0);
        end
        chk("ovf_none", {31'd0, overflow}, 32'd0);

        // simultaneous press btn3 + btn1 with no consumer
        keyReady = 1'b0;
        btnRaw = 5'b01010;
        ticks(4);
        chk("sim_pulse", {27'd0, pressPulse}, 32'h0a);
        sb.push_back(3'd1);
        @(negedge clk);
        chk("sim_valid", {31'd0, keyValid}, 32'd1);
        chk("sim_code",  {29'd0, keyCode}, 32'd1);
        chk("sim_ovf",   {31'd0, overflow}, 32'd1);
        clear_ovf();

        // back-pressure: second press while full
        btnRaw = 5'b00000;
        ticks(4);
        btnRaw = 5'b10000;
        ticks(4);
        chk("bp_pulse", {27'd0, pressPulse}, 32'h10);
        @(negedge clk);
        chk("bp_valid", {31'd0, keyValid}, 32'd1);
        chk("bp_code",  {29'd0, keyCode}, 32'd1);
        chk("bp_ovf",   {31'd0, overflow}, 32'd1);
        clear_ovf();

        // drop concurrent with clrOvf: drop wins
        btnRaw = 5'b00000;
        ticks(4);
        btnRaw = 5'b10000;
        ticks(4);
        clrOvf = 1'b1;
        @(negedge clk);
        clrOvf = 1'b0;
        chk("drop_wins", {31'd0, overflow}, 32'd1);
        clear_ovf();

        // drain and new pulse in the same cycle
        btnRaw = 5'b10001;
        ticks(4);
        chk("dr_pulse", {27'd0, pressPulse}, 32'h01);
        sb.push_back(3'd0);
        keyReady = 1'b1;
        @(negedge clk);
        chk("dr_valid", {31'd0, keyValid}, 32'd1);
        chk("dr_code",  {29'd0, keyCode}, 32'd0);
        @(negedge clk);
        chk("dr_empty", {31'd0, keyValid}, 32'd0);
        chk("dr_ovf",   {31'd0, overflow}, 32'd0);

        // reset mid-event and mid-debounce
        keyReady = 1'b0;
        btnRaw = 5'b00000;
        ticks(4);
        btnRaw = 5'b01000;
        ticks(4);
        btnRaw = 5'b01100;
        ticks(3);
        chk("pre_lvl",   {27'd0, btnLevel}, 32'h08);
        chk("pre_valid", {31'd0, keyValid}, 32'd1);
        chk("pre_code",  {29'd0, keyCode}, 32'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_level", {27'd0, btnLevel}, 32'd0);
        chk("ar_valid", {31'd0, keyValid}, 32'd0);
        chk("ar_code",  {29'd0, keyCode}, 32'd0);
        keyReady = 1'b1;
        readTick = 1'b1;
        repeat (3) @(negedge clk);
        readTick = 1'b0;
        chk("ir_level", {27'd0, btnLevel}, 32'd0);
        chk("ir_pulse", {27'd0, pressPulse}, 32'd0);
        chk("ir_valid", {31'd0, keyValid}, 32'd0);
        chk("ir_ovf",   {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_pls[%0d]", k), {27'd0, pressPulse}, 32'd0);
            chk($sformatf("post_lvl[%0d]", k), {27'd0, btnLevel}, 32'd0);
        end
        sb.push_back(3'd2);
        tick();
        chk("post_pulse", {27'd0, pressPulse}, 32'h0c);
        @(negedge clk);
        chk("post_ovf", {31'd0, overflow}, 32'd1);
        chk("post_lvl", {27'd0, btnLevel}, 32'h0c);

        repeat (20) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_reader.md
BTN_READER -- requirements
Module: btn_reader

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5: number of push-buttons.
REQ-002 SHALL have parameter DEBOUNCE_N, default 4: consecutive agreeing samples needed to accept a level change, legal range 2..15.
REQ-003 SHALL have port clk, input, 1: the single system clock; all flops on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port readTick, input, 1: one-clk-cycle sample enable from the clock divider, synchronous to clk.
REQ-006 SHALL have port btnRaw, input, NUM_BTN: raw asynchronous button levels, 1 = pressed.
REQ-007 SHALL have port btnLevel, output, NUM_BTN: debounced button levels.
REQ-008 SHALL have port pressPulse, output, NUM_BTN: one-cycle strobe on each accepted press.
REQ-009 SHALL have port keyValid, output, 1: the key event register holds an event.
REQ-010 SHALL have port keyCode, output, 3: index of the button in the held event.
REQ-011 SHALL have port keyReady, input, 1: the consumer accepts the event.
REQ-012 SHALL have port overflow, output, 1: sticky flag, an event was dropped.
REQ-013 SHALL have port clrOvf, input, 1: clears overflow.

Function
REQ-014 SHALL pass each btnRaw bit through a 2-flop synchronizer clocked every clk cycle.
REQ-015 SHALL advance each per-button FSM only in cycles with readTick=1; with readTick=0, state and counter hold.
REQ-016 SHALL use FSM states IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-017 IDLE, sample 1: go to PRESS_WAIT with cnt=1. IDLE, sample 0: stay in IDLE.
REQ-018 PRESS_WAIT, sample 1: cnt+1; when cnt reaches DEBOUNCE_N, go to HELD. PRESS_WAIT, sample 0: go to IDLE with cnt=0.
REQ-019 HELD, sample 0: go to REL_WAIT with cnt=1. HELD, sample 1: stay in HELD.
REQ-020 REL_WAIT, sample 0: cnt+1; when cnt reaches DEBOUNCE_N, go to IDLE. REL_WAIT, sample 1: go to HELD with cnt=0.
REQ-021 btnLevel SHALL be 1 exactly in HELD and REL_WAIT, registered.
REQ-022 pressPulse[i] SHALL be high for exactly the one clk cycle after the tick that enters HELD from PRESS_WAIT; a REL_WAIT->HELD return SHALL NOT pulse.
REQ-023 Counter width SHALL be 4 bits; it SHALL saturate at DEBOUNCE_N and never wrap.
REQ-024 Event register, empty with any pressPulse bit set: load the lowest set index into keyCode and set keyValid next cycle.
REQ-025 While keyValid=1, keyCode SHALL stay stable until the cycle keyValid&keyReady; keyValid then clears next cycle unless a reload occurs in the same cycle.
REQ-026 Drain and new pulse in the same cycle: load the new event; keyValid stays 1.
REQ-027 More than one pulse bit in a cycle: load the lowest index, drop the others, set overflow.
REQ-028 Pulse while full and not draining: drop the pulse, keep the held event, set overflow.
REQ-029 clrOvf=1 SHALL clear overflow next cycle; a concurrent drop event SHALL win and overflow stays 1.

Reset
REQ-030 On rst=0, all FSMs go to IDLE, cnt=0, synchronizers=0, btnLevel=0, pressPulse=0, keyValid=0, keyCode=0, overflow=0, asynchronously.
REQ-031 Reset mid-debounce or mid-event SHALL discard all progress; readTick, btnRaw and keyReady SHALL be ignored while rst=0.
REQ-032 After rst deasserts, a button held throughout SHALL need a full DEBOUNCE_N ticks before its press is accepted.

Structure
REQ-033 Shared package btn_pkg SHALL hold the FSM state typedef, the NUM_BTN default, and the keyCode width constant.
REQ-034 The synchronizer, FSM and counter SHALL be sub-module btn_debounce, instanced NUM_BTN times; priority encode and the event register SHALL stay in btn_reader.

Verification
REQ-035 Scenario, clean press: btnRaw[2]=1 held, readTick every 10 cycles -> pressPulse[2] one cycle after the 4th tick, keyValid=1 with keyCode=2, btnLevel[2]=1.
REQ-036 Scenario, bounce: btnRaw[0] pattern 1,1,0,1,1,1,1 across ticks -> one pressPulse only, after the 4th consecutive 1.
REQ-037 Scenario, release glitch: btnRaw[1] held, then 0 for 2 ticks, then 1 -> btnLevel[1] stays 1, no second pulse.
REQ-038 Scenario, simultaneous press: btnRaw[3] and btnRaw[1] pressed on the same tick, keyReady=0 -> keyCode=1, overflow=1.
REQ-039 Scenario, back-pressure: event held with keyReady=0, then a second press -> keyCode unchanged, overflow=1; then clrOvf=1 -> overflow=0.
REQ-040 Scenario, reset: rst=0 pulse during PRESS_WAIT with cnt=3 -> all outputs 0; pulse only after 4 further ticks.
